// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver. Define UART_RX_MAJORITY_EN to take a
// 2-of-3 vote over the last three oversample ticks of each data/stop bit.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 bit_sample;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] early;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The third vote is the live rx_s at the last tick, so only two samples are stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      early <= 2'b00;
    end else if (b_tick && (state == DATA || state == STOP)) begin
      if (tick_cnt == TW'(OVERSAMPLE - 3)) begin
        early[0] <= rx_s;
      end else if (tick_cnt == TW'(OVERSAMPLE - 2)) begin
        early[1] <= rx_s;
      end else begin
        early <= early;
      end
    end else begin
      early <= early;
    end
  end

  assign bit_sample = maj3(early[0], early[1], rx_s);
`else
  assign bit_sample = rx_s;
`endif

  // Receive FSM with registered outputs; outside IDLE it only moves on b_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end else begin
            rx_busy <= 1'b0;
          end
        end
        START: begin
          if (b_tick) begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (b_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {bit_sample, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (b_tick) begin
            if (tick_cnt == TICK_LAST) begin
              // Data is delivered even when the stop bit is bad.
              tick_cnt  <= '0;
              rx_data   <= shift_reg;
              frame_err <= ~bit_sample;
              rx_done   <= 1'b1;
              rx_busy   <= 1'b0;
              state     <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          rx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
